// File: rtl/vs_pkg.sv
// Shared types, default memory map and wide fixed-point helpers for variable_step_ctrl.
// Helpers work in a 128-bit signed domain and saturate to the caller's word width (DATA_W <= 126).
package vs_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SCAN   = 3'd2,
    S_DECIDE = 3'd3,
    S_CLAMP  = 3'd4,
    S_WRITE  = 3'd5,
    S_DONE   = 3'd6
  } vs_state_t;

  localparam int VS_WIDE_W = 128;
  typedef logic signed [VS_WIDE_W-1:0] vs_wide_t;

  localparam int DEF_N_ADDR    = 0;
  localparam int DEF_T_ADDR    = 1;
  localparam int DEF_TEND_ADDR = 2;
  localparam int DEF_H_ADDR    = 17;
  localparam int DEF_TOL_ADDR  = 18;
  localparam int DEF_XA_BASE   = 119;
  localparam int DEF_XB_BASE   = 169;

  function automatic vs_wide_t max_pos(input int w);
    return (vs_wide_t'(1'b1) <<< (w - 1)) - vs_wide_t'(1'b1);
  endfunction

  // Sign-extend the low w bits of v across the wide domain.
  function automatic vs_wide_t sext(input vs_wide_t v, input int w);
    return (v <<< (VS_WIDE_W - w)) >>> (VS_WIDE_W - w);
  endfunction

  function automatic vs_wide_t to_fix(input int whole, input int frac_w);
    return vs_wide_t'(whole) <<< frac_w;
  endfunction

  function automatic vs_wide_t sat_abs(input vs_wide_t x, input int w);
    vs_wide_t m;
    vs_wide_t a;
    m = max_pos(w);
    a = (x < vs_wide_t'(1'b0)) ? -x : x;
    return (a > m) ? m : a;
  endfunction

  function automatic vs_wide_t sat_add(input vs_wide_t a, input vs_wide_t b, input int w);
    vs_wide_t s;
    vs_wide_t m;
    s = a + b;
    m = max_pos(w);
    if (s > m) return m;
    if (s < (-m - vs_wide_t'(1'b1))) return -m - vs_wide_t'(1'b1);
    return s;
  endfunction

  function automatic vs_wide_t def_hmin(input int frac_w);
    return to_fix(1, frac_w - 10);
  endfunction

  function automatic vs_wide_t def_hmax(input int frac_w);
    return to_fix(1, frac_w);
  endfunction

endpackage

// File: rtl/variable_step_ctrl_err_acc.sv
// vs_err_acc: running |a-b| error tracker with reject/grow flags.
// Build option VS_RELERR_EN switches to per-component thresholds tol + (|b| >> 4).
module vs_err_acc
  import vs_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int GROW_SHIFT = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] tol,
  output logic              reject,
  output logic              grow
);

  function automatic vs_wide_t wide(input logic [DATA_W-1:0] v);
    return sext(vs_wide_t'(v), DATA_W);
  endfunction

  vs_wide_t d_s;
  assign d_s = sat_abs(wide(a) - wide(b), DATA_W);

`ifdef VS_RELERR_EN
  vs_wide_t thr_s;
  logic     rej_r;
  logic     nogrow_r;

  assign thr_s = sat_add(wide(tol), sat_abs(wide(b), DATA_W) >>> 4, DATA_W);

  // Sticky per-component fail flags against the relative threshold.
  always_ff @(posedge clk) begin
    if (reset) begin
      rej_r    <= 1'b0;
      nogrow_r <= 1'b0;
    end else if (enable) begin
      if (clear) begin
        rej_r    <= 1'b0;
        nogrow_r <= 1'b0;
      end else if (valid) begin
        if (d_s > thr_s) rej_r <= 1'b1;
        if (d_s > (thr_s >>> GROW_SHIFT)) nogrow_r <= 1'b1;
      end
    end
  end

  assign reject = rej_r;
  assign grow   = ~nogrow_r;
`else
  logic [DATA_W-1:0] err_r;

  // Running max-norm of the component differences.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r <= '0;
    end else if (enable) begin
      if (clear) begin
        err_r <= '0;
      end else if (valid && (d_s > wide(err_r))) begin
        err_r <= d_s[DATA_W-1:0];
      end
    end
  end

  assign reject = wide(err_r) > wide(tol);
  assign grow   = wide(err_r) <= (wide(tol) >>> GROW_SHIFT);
`endif

endmodule

// File: rtl/variable_step_ctrl.sv
// Adaptive step-size controller: loads solver state, scans XA/XB error, writes the new h.
// Optional build macro VS_RELERR_EN selects the relative per-component error test.
module variable_step_ctrl
  import vs_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int FRAC_W     = 32,
  parameter int ADDR_W     = 11,
  parameter int MAX_N      = 50,
  parameter int N_ADDR     = DEF_N_ADDR,
  parameter int T_ADDR     = DEF_T_ADDR,
  parameter int TEND_ADDR  = DEF_TEND_ADDR,
  parameter int H_ADDR     = DEF_H_ADDR,
  parameter int TOL_ADDR   = DEF_TOL_ADDR,
  parameter int XA_BASE    = DEF_XA_BASE,
  parameter int XB_BASE    = DEF_XB_BASE,
  parameter int GROW_SHIFT = 5,
  parameter logic [DATA_W-1:0] HMIN = DATA_W'(def_hmin(FRAC_W)),
  parameter logic [DATA_W-1:0] HMAX = DATA_W'(def_hmax(FRAC_W))
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              start_cal_err,
  output logic [ADDR_W-1:0] address_bus,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in,
  output logic              mem_wr_enable,
  output logic              h_done,
  output logic              error_ok,
  output logic              h_min_hit,
  output logic [DATA_W-1:0] h_out
);

  localparam int IDX_W = $clog2(MAX_N + 1);

  function automatic vs_wide_t wide(input logic [DATA_W-1:0] v);
    return sext(vs_wide_t'(v), DATA_W);
  endfunction

  vs_state_t         state_r;
  logic [3:0]        cnt_r;
  logic [IDX_W-1:0]  i_r;
  logic [IDX_W-1:0]  n_r;
  logic [DATA_W-1:0] h_r, t_r, tend_r, tol_r, a_r, h_new_r;
  logic              accept_r, min_hit_r;
  logic              acc_clear_s, acc_valid_s, acc_reject_s, acc_grow_s;
  vs_wide_t          half_s, dbl_s, sum_s, decided_s, clamped_s;

  assign acc_clear_s = (state_r == S_IDLE) && start_cal_err;
  assign acc_valid_s = (state_r == S_SCAN) && (cnt_r == 4'd3);

  vs_err_acc #(.DATA_W(DATA_W), .GROW_SHIFT(GROW_SHIFT)) u_acc (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (acc_clear_s),
    .valid  (acc_valid_s),
    .a      (a_r),
    .b      (data_in),
    .tol    (tol_r),
    .reject (acc_reject_s),
    .grow   (acc_grow_s)
  );

  // Step decision (used in DECIDE) and end-time clamp (used in CLAMP).
  always_comb begin
    half_s = wide(h_r) >>> 1;
    dbl_s  = sat_add(wide(h_r), wide(h_r), DATA_W);
    if (acc_reject_s) begin
      decided_s = (half_s < wide(HMIN)) ? wide(HMIN) : half_s;
    end else if (acc_grow_s) begin
      decided_s = (dbl_s > wide(HMAX)) ? wide(HMAX) : dbl_s;
    end else begin
      decided_s = wide(h_r);
    end
    sum_s = sat_add(wide(t_r), wide(h_new_r), DATA_W);
    if (accept_r && (wide(tend_r) > wide(t_r)) && (sum_s > wide(tend_r))) begin
      clamped_s = wide(tend_r) - wide(t_r);
    end else begin
      clamped_s = wide(h_new_r);
    end
  end

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_IDLE;
      cnt_r         <= 4'd0;
      i_r           <= '0;
      n_r           <= '0;
      h_r           <= '0;
      t_r           <= '0;
      tend_r        <= '0;
      tol_r         <= '0;
      a_r           <= '0;
      h_new_r       <= '0;
      accept_r      <= 1'b0;
      min_hit_r     <= 1'b0;
      address_bus   <= '0;
      data_out      <= '0;
      mem_wr_enable <= 1'b0;
      h_done        <= 1'b0;
      error_ok      <= 1'b0;
      h_min_hit     <= 1'b0;
      h_out         <= '0;
    end else if (enable) begin
      case (state_r)
        S_IDLE: begin
          h_done <= 1'b0;
          if (start_cal_err) begin
            state_r     <= S_LOAD;
            cnt_r       <= 4'd0;
            address_bus <= ADDR_W'(N_ADDR);
            error_ok    <= 1'b0;
            h_min_hit   <= 1'b0;
          end
        end
        // Even counts present an address, odd counts capture the word.
        S_LOAD: begin
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r[0]) begin
            case (cnt_r)
              4'd1: begin
                n_r         <= (data_in > DATA_W'(MAX_N)) ? IDX_W'(MAX_N) : data_in[IDX_W-1:0];
                address_bus <= ADDR_W'(H_ADDR);
              end
              4'd3: begin
                h_r         <= data_in;
                address_bus <= ADDR_W'(T_ADDR);
              end
              4'd5: begin
                t_r         <= data_in;
                address_bus <= ADDR_W'(TEND_ADDR);
              end
              4'd7: begin
                tend_r      <= data_in;
                address_bus <= ADDR_W'(TOL_ADDR);
              end
              default: begin
                tol_r       <= data_in;
                cnt_r       <= 4'd0;
                i_r         <= '0;
                address_bus <= ADDR_W'(XA_BASE);
                state_r     <= (n_r == IDX_W'(1'b0)) ? S_DECIDE : S_SCAN;
              end
            endcase
          end
        end
        S_SCAN: begin
          cnt_r <= cnt_r + 4'd1;
          case (cnt_r)
            4'd1: begin
              a_r         <= data_in;
              address_bus <= ADDR_W'(XB_BASE) + ADDR_W'(i_r);
            end
            4'd3: begin
              cnt_r <= 4'd0;
              if (i_r == (n_r - IDX_W'(1'b1))) begin
                state_r     <= S_DECIDE;
                address_bus <= '0;
              end else begin
                i_r         <= i_r + IDX_W'(1'b1);
                address_bus <= ADDR_W'(XA_BASE) + ADDR_W'(i_r) + ADDR_W'(1'b1);
              end
            end
            default: begin
            end
          endcase
        end
        S_DECIDE: begin
          accept_r  <= ~acc_reject_s;
          min_hit_r <= acc_reject_s && (h_r == HMIN);
          h_new_r   <= decided_s[DATA_W-1:0];
          state_r   <= S_CLAMP;
        end
        S_CLAMP: begin
          h_new_r       <= clamped_s[DATA_W-1:0];
          data_out      <= clamped_s[DATA_W-1:0];
          address_bus   <= ADDR_W'(H_ADDR);
          mem_wr_enable <= 1'b1;
          state_r       <= S_WRITE;
        end
        S_WRITE: begin
          mem_wr_enable <= 1'b0;
          address_bus   <= '0;
          state_r       <= S_DONE;
        end
        S_DONE: begin
          h_done    <= 1'b1;
          h_out     <= h_new_r;
          error_ok  <= accept_r;
          h_min_hit <= min_hit_r;
          state_r   <= S_IDLE;
        end
        default: begin
          mem_wr_enable <= 1'b0;
          state_r       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_variable_step_ctrl.sv
// Directed, table-driven bench for variable_step_ctrl (default absolute-error build).
module tb_variable_step_ctrl;

  logic        clk = 1'b0;
  logic        reset, enable, start_cal_err;
  logic [10:0] address_bus;
  logic [63:0] data_out, data_in, h_out;
  logic        mem_wr_enable, h_done, error_ok, h_min_hit;

  variable_step_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .start_cal_err(start_cal_err),
    .address_bus(address_bus), .data_out(data_out), .data_in(data_in),
    .mem_wr_enable(mem_wr_enable), .h_done(h_done), .error_ok(error_ok),
    .h_min_hit(h_min_hit), .h_out(h_out)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [0:2047];
  logic [63:0] wr_data = 64'd0;
  logic [10:0] wr_addr = 11'd0;
  int          wr_count = 0;

  // One-cycle read latency memory; writes are logged rather than stored.
  always @(posedge clk) begin
    data_in <= mem[address_bus];
    if (mem_wr_enable) begin
      wr_count <= wr_count + 1;
      wr_data  <= data_out;
      wr_addr  <= address_bus;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string what, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", what, act, exp);
    end
  endtask

  function automatic longint fx(input real r);
    return longint'(r * 4294967296.0);
  endfunction

  localparam longint ONE  = 64'sd4294967296;
  localparam longint HMIN = 64'sd4194304;

  typedef struct {
    longint n, h, t, tend, tol;
    longint xa[3];
    longint xb[3];
    longint exp_h;
    bit     exp_ok;
    bit     exp_min;
  } vec_t;

  function automatic vec_t mk(input longint n, h, t, tend, tol, a0, a1, a2, b0, b1, b2,
                              input longint eh, input bit ok, input bit mn);
    vec_t v;
    v.n = n; v.h = h; v.t = t; v.tend = tend; v.tol = tol;
    v.xa[0] = a0; v.xa[1] = a1; v.xa[2] = a2;
    v.xb[0] = b0; v.xb[1] = b1; v.xb[2] = b2;
    v.exp_h = eh; v.exp_ok = ok; v.exp_min = mn;
    return v;
  endfunction

  task automatic load_mem(input vec_t v);
    for (int i = 0; i < 2048; i++) mem[i] = 64'd0;
    mem[0]  = v.n;  mem[17] = v.h;  mem[1] = v.t;
    mem[2]  = v.tend; mem[18] = v.tol;
    for (int i = 0; i < 3; i++) begin
      mem[119 + i] = v.xa[i];
      mem[169 + i] = v.xb[i];
    end
  endtask

  task automatic run_op(input int freeze_at, input int freeze_len, output int lat);
    @(negedge clk);
    start_cal_err = 1'b1;
    @(posedge clk); #1;
    start_cal_err = 1'b0;
    lat = 0;
    while (lat < 1000) begin
      @(posedge clk); #1;
      lat++;
      if (h_done) break;
      if (lat == freeze_at) begin
        enable = 1'b0;
        repeat (freeze_len) @(posedge clk);
        #1;
        enable = 1'b1;
        lat += freeze_len;
      end
    end
  endtask

  task automatic apply(input string tag, input vec_t v, input int freeze_at, input int freeze_len,
                       input int exp_lat);
    int lat;
    int wc0;
    wc0 = wr_count;
    run_op(freeze_at, freeze_len, lat);
    check({tag, " latency"},   longint'(lat), longint'(exp_lat));
    check({tag, " h_out"},     longint'(h_out), v.exp_h);
    check({tag, " error_ok"},  longint'(error_ok), longint'(v.exp_ok));
    check({tag, " h_min_hit"}, longint'(h_min_hit), longint'(v.exp_min));
    check({tag, " writes"},    longint'(wr_count - wc0), 64'sd1);
    check({tag, " wr_addr"},   longint'(wr_addr), 64'sd17);
    check({tag, " wr_data"},   longint'(wr_data), v.exp_h);
    @(posedge clk); #1;
    check({tag, " h_done pulse"}, longint'(h_done), 64'sd0);
  endtask

  vec_t vecs[12];
  vec_t big;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   lat;
    int   wc0;
    int   seen;
    longint h1, tol2;
    h1   = fx(0.1);
    tol2 = fx(0.02);

    vecs[0]  = mk(3, h1, ONE, fx(2.0), tol2, fx(1.0), fx(2.0), fx(3.0),
                  fx(1.0), fx(2.0), fx(3.0), 2 * h1, 1'b1, 1'b0);
    vecs[1]  = mk(3, h1, ONE, fx(2.0), tol2, fx(1.0), fx(2.0), fx(3.0),
                  fx(1.0), fx(2.0), fx(3.05), h1 >>> 1, 1'b0, 1'b0);
    vecs[2]  = mk(3, h1, ONE, fx(2.0), tol2, fx(1.0), fx(2.0), fx(3.0),
                  fx(1.0), fx(2.0), fx(3.01), h1, 1'b1, 1'b0);
    vecs[3]  = mk(3, h1, fx(1.9), fx(2.0), tol2, fx(1.0), fx(2.0), fx(3.0),
                  fx(1.0), fx(2.0), fx(3.0), fx(2.0) - fx(1.9), 1'b1, 1'b0);
    vecs[4]  = mk(3, fx(0.8), 0, fx(2.0), tol2, fx(1.0), fx(2.0), fx(3.0),
                  fx(1.0), fx(2.0), fx(3.0), ONE, 1'b1, 1'b0);
    vecs[5]  = mk(3, HMIN, ONE, fx(2.0), tol2, fx(1.0), fx(2.0), fx(3.0),
                  fx(1.0), fx(2.0), fx(3.05), HMIN, 1'b0, 1'b1);
    vecs[6]  = mk(0, h1, ONE, fx(2.0), tol2, fx(5.0), 0, 0,
                  fx(-5.0), 0, 0, 2 * h1, 1'b1, 1'b0);
    vecs[7]  = mk(1, h1, ONE, fx(2.0), tol2, 64'sh7FFF_FFFF_FFFF_FFFF, 0, 0,
                  64'sh8000_0000_0000_0000, 0, 0, h1 >>> 1, 1'b0, 1'b0);
    vecs[8]  = mk(3, h1, fx(2.5), fx(2.0), tol2, fx(1.0), fx(2.0), fx(3.0),
                  fx(1.0), fx(2.0), fx(3.0), 2 * h1, 1'b1, 1'b0);
    vecs[9]  = mk(3, h1, ONE, fx(2.0), tol2, fx(1.0), fx(2.01), fx(3.0),
                  fx(1.0), fx(2.0), fx(3.0), h1, 1'b1, 1'b0);
    vecs[10] = mk(3, h1, ONE, fx(2.0), tol2, fx(1.0), fx(2.0), fx(3.0),
                  fx(1.0), fx(2.0), fx(3.0) + (tol2 >>> 5), 2 * h1, 1'b1, 1'b0);
    vecs[11] = mk(3, h1, ONE, fx(2.0), tol2, fx(1.0), fx(2.0), fx(3.0),
                  fx(1.0), fx(2.0), fx(3.0) + tol2, h1, 1'b1, 1'b0);

    reset = 1'b1; enable = 1'b1; start_cal_err = 1'b0;
    load_mem(vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    check("reset address_bus",   longint'(address_bus), 64'sd0);
    check("reset mem_wr_enable", longint'(mem_wr_enable), 64'sd0);
    check("reset h_done",        longint'(h_done), 64'sd0);
    check("reset error_ok",      longint'(error_ok), 64'sd0);
    check("reset h_out",         longint'(h_out), 64'sd0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 12; k++) begin
      load_mem(vecs[k]);
      apply($sformatf("vec%0d", k), vecs[k], -1, 0, 14 + 4 * int'(vecs[k].n));
    end

    // N above MAX_N scans only 50 components; the last one carries the error.
    big = vecs[1];
    load_mem(big);
    mem[0] = 64'd60;
    for (int i = 0; i < 50; i++) begin
      mem[119 + i] = fx(1.0);
      mem[169 + i] = (i == 49) ? fx(1.05) : fx(1.0);
    end
    apply("nclamp", big, -1, 0, 214);

    // Freeze for 7 cycles in the middle of SCAN.
    load_mem(vecs[0]);
    apply("freeze", vecs[0], 14, 7, 33);

    // Reset in the middle of SCAN: no write, outputs cleared, no completion.
    load_mem(vecs[0]);
    wc0 = wr_count;
    @(negedge clk);
    start_cal_err = 1'b1;
    @(posedge clk); #1;
    start_cal_err = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midreset h_out",    longint'(h_out), 64'sd0);
    check("midreset error_ok", longint'(error_ok), 64'sd0);
    check("midreset address",  longint'(address_bus), 64'sd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (h_done || mem_wr_enable) seen++;
    end
    check("midreset no activity", longint'(seen), 64'sd0);
    check("midreset no write",    longint'(wr_count - wc0), 64'sd0);
    load_mem(vecs[1]);
    apply("post_reset", vecs[1], -1, 0, 26);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
